// File: rtl/a2d_pkg.sv
// Shared types and helpers for the round-robin A2D SPI front end.
// Holds the channel/state encodings and the command-word builder.
package a2d_pkg;

  localparam logic [1:0]  CMD_PAD_HI = 2'b00;
  localparam logic [10:0] CMD_PAD_LO = 11'h000;

  typedef enum logic [2:0] {
    CH_LFT  = 3'd0,
    CH_RGHT = 3'd4,
    CH_BATT = 3'd5
  } chnl_e;

  typedef enum logic [2:0] {
    RR_IDLE,
    RR_CMD,
    RR_GAP,
    RR_READ,
    RR_UPD
  } rr_state_e;

  typedef enum logic [1:0] {
    SPI_IDLE,
    SPI_FRONT,
    SPI_SHIFT,
    SPI_BACK
  } spi_state_e;

  // Channel number sits in bits [13:11] of the 16-bit command.
  function automatic logic [15:0] mk_cmd(input chnl_e ch);
    return {CMD_PAD_HI, ch, CMD_PAD_LO};
  endfunction

  function automatic chnl_e next_chnl(input chnl_e ch);
    case (ch)
      CH_LFT:  return CH_RGHT;
      CH_RGHT: return CH_BATT;
      default: return CH_LFT;
    endcase
  endfunction

endpackage

// File: rtl/a2d_rr_intf_spi_mstr16.sv
// 16-bit SPI master (CPOL=1, CPHA=1) with SCLK derived from a free divider MSB.
// One wrt launches one frame; done pulses once SS_n has returned high.
module spi_mstr16
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [SCLK_DIV_W-1:0] DIV_LOAD = {2'b10, {(SCLK_DIV_W-2){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] DIV_FALL = '1;

  spi_state_e            state;
  logic [SCLK_DIV_W-1:0] div_cnt;
  logic [3:0]            bit_cnt;
  logic [15:0]           shft;
  logic                  sclk_rise;
  logic                  sclk_fall;

  // Decodes of the cycle before SCLK changes, so actions land on the same edge.
  assign sclk_rise = (div_cnt == DIV_RISE);
  assign sclk_fall = (div_cnt == DIV_FALL);
  assign SCLK      = div_cnt[SCLK_DIV_W-1];
  assign rd_data   = shft;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SPI_IDLE;
      div_cnt <= '1;
      bit_cnt <= '0;
      shft    <= '0;
      SS_n    <= 1'b1;
      MOSI    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        SPI_IDLE: begin
          if (wrt) begin
            state   <= SPI_FRONT;
            div_cnt <= DIV_LOAD;
            bit_cnt <= '0;
            shft    <= cmd;
            MOSI    <= cmd[15];
            SS_n    <= 1'b0;
          end
        end
        // First fall only opens the window; bit 15 is already on MOSI.
        SPI_FRONT: begin
          div_cnt <= div_cnt + 1'b1;
          if (sclk_fall) state <= SPI_SHIFT;
        end
        SPI_SHIFT: begin
          div_cnt <= div_cnt + 1'b1;
          if (sclk_rise) begin
            shft    <= {shft[14:0], MISO};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'hF) state <= SPI_BACK;
          end
          if (sclk_fall) MOSI <= shft[15];
        end
        // Hold SCLK high by stopping the divider at all-ones.
        SPI_BACK: begin
          if (sclk_fall) begin
            state <= SPI_IDLE;
            SS_n  <= 1'b1;
            done  <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= SPI_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/a2d_rr_intf.sv
// Round-robin A2D front end: converts channels 0, 4, 5 in turn, one per nxt pulse.
// Each conversion is a command frame followed by a read frame with the same word.
module a2d_rr_intf
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  rr_state_e   state;
  chnl_e       chnl;
  logic        wrt;
  logic        done;
  logic [15:0] cmd;
  logic [15:0] rd_data;
  logic [3:0]  rx_hdr_unused;

  // The SPI master is idle in both IDLE and GAP, so wrt is never dropped.
  assign wrt           = ((state == RR_IDLE) && nxt) || (state == RR_GAP);
  assign cmd           = mk_cmd(chnl);
  assign rx_hdr_unused = rd_data[15:12];

  spi_mstr16 #(
    .SCLK_DIV_W(SCLK_DIV_W)
  ) u_spi (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrt    (wrt),
    .cmd    (cmd),
    .done   (done),
    .rd_data(rd_data),
    .SS_n   (SS_n),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO   (MISO)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RR_IDLE;
      chnl      <= CH_LFT;
      lft_ld    <= '0;
      rght_ld   <= '0;
      batt      <= '0;
      cnv_cmplt <= 1'b0;
    end else begin
      cnv_cmplt <= 1'b0;
      case (state)
        RR_IDLE: if (nxt)  state <= RR_CMD;
        RR_CMD:  if (done) state <= RR_GAP;
        RR_GAP:            state <= RR_READ;
        RR_READ: if (done) state <= RR_UPD;
        RR_UPD: begin
          case (chnl)
            CH_LFT:  lft_ld  <= rd_data[11:0];
            CH_RGHT: rght_ld <= rd_data[11:0];
            default: batt    <= rd_data[11:0];
          endcase
          cnv_cmplt <= 1'b1;
          chnl      <= next_chnl(chnl);
          state     <= RR_IDLE;
        end
        default: state <= RR_IDLE;
      endcase
    end
  end

endmodule
